// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        DZERO = 2'b10,
        DONE  = 2'b11
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 4;

endpackage

// File: rtl/seq_div_ctrl.sv
// Divider sequencer: four-state FSM plus iteration counter, issuing load/shift/dzero/fin strobes.
module seq_div_ctrl
    import seq_div_pkg::*;
#(
    parameter int unsigned N = DIV_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic divisor_zero,
    output logic load,
    output logic shift,
    output logic dzero,
    output logic fin,
    output logic busy
);

    localparam int unsigned CW = $clog2(N);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        dzero   = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (divisor_zero) begin
                        state_d = DZERO;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            CALC: begin
                shift = 1'b1;
                // The cycle that sees a zero count is the N-th iteration.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DZERO: begin
                dzero   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: datapath registers and result holding.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned N = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    logic         load, shift, dzero, fin;
    logic [N:0]   r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] d_q, d_d;
    logic         dz_seen_q, dz_seen_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [N-1:0] remainder_q, remainder_d;
    logic         dbz_q, dbz_d;
    logic         done_q, done_d;
    logic [N:0]   r_sh;
    logic [N+1:0] trial;

    seq_div_ctrl #(.N(N)) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .divisor_zero (divisor == '0),
        .load         (load),
        .shift        (shift),
        .dzero        (dzero),
        .fin          (fin),
        .busy         (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            dz_seen_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            dz_seen_q   <= dz_seen_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        dz_seen_d   = dz_seen_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        r_sh        = {r_q[N-1:0], q_q[N-1]};
        // One extra bit so the sign of the trial subtraction is visible.
        trial       = {1'b0, r_sh} - {2'b00, d_q};

        if (load) begin
            r_d       = '0;
            q_d       = dividend;
            d_d       = divisor;
            dz_seen_d = (divisor == '0);
        end
        if (shift) begin
            if (!trial[N+1]) begin
                r_d = trial[N:0];
                q_d = {q_q[N-2:0], 1'b1};
            end else begin
                r_d = r_sh;
                q_d = {q_q[N-2:0], 1'b0};
            end
        end
        if (dzero) begin
            q_d = '1;
            r_d = {1'b0, q_q};
        end
        if (fin) begin
            quotient_d  = q_q;
            remainder_d = r_q[N-1:0];
            dbz_d       = dz_seen_q;
            done_d      = 1'b1;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): latency, results, busy handling, reset and full operand sweep.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_cmp;
    int n_bad;

    seq_divider #(.N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts from a point 1 time unit after a rising edge with the block idle.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                           input logic [3:0] eq, input logic [3:0] er, input logic ez,
                           input string tag);
        int lat;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, ez);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int          dones;
        logic [3:0]  eq, er;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_div(4'd13, 4'd3, 5, 4'd4, 4'd1, 1'b0, "d13_3");
        run_div(4'd15, 4'd1, 5, 4'd15, 4'd0, 1'b0, "d15_1");
        run_div(4'd7, 4'd9, 5, 4'd0, 4'd7, 1'b0, "d7_9");
        run_div(4'd9, 4'd0, 2, 4'hF, 4'd9, 1'b1, "d9_0");
        run_div(4'd8, 4'd2, 5, 4'd4, 4'd0, 1'b0, "d8_2");

        // start pulsed while busy must not disturb 12/5
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(posedge clk); #1;
        start    = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        dones    = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                chk("busy_q", quotient, 4'd2);
                chk("busy_r", remainder, 4'd2);
                chk("busy_after", busy, 0);
            end
            @(posedge clk); #1;
        end
        chk("busy_ndone", dones, 1);

        // held start: next operation accepted on the first idle edge after the result
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("held_done", done, 1);
        chk("held_idle", busy, 0);
        @(posedge clk); #1;
        chk("held_reaccept", busy, 1);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // reset during the second CALC cycle of 14/3
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_q", quotient, 0);
        chk("mrst_r", remainder, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_dz", div_by_zero, 0);
        #4 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("mrst_nodone", dones, 0);
        run_div(4'd14, 4'd3, 5, 4'd4, 4'd2, 1'b0, "d14_3");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    run_div(4'(a), 4'd0, 2, 4'hF, 4'(a), 1'b1, "sweep");
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    run_div(4'(a), 4'(b), 5, eq, er, 1'b0, "sweep");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, the request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, N, the unsigned dividend, captured on start acceptance.
REQ-006 The block SHALL have port divisor, input, N, the unsigned divisor, captured on start acceptance.
REQ-007 The block SHALL have port quotient, output, N, the registered quotient result.
REQ-008 The block SHALL have port remainder, output, N, the registered remainder result.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when results become valid.
REQ-011 The block SHALL have port div_by_zero, output, 1, which is valid with done and held with the results.

Function
REQ-012 The block SHALL implement an unsigned restoring shift-subtract division using an internal (N+1)-bit partial remainder R, an N-bit quotient/shift register Q, a divisor register D, and an iteration counter of clog2(N) bits.
REQ-013 The FSM SHALL use exactly four states: IDLE, CALC, DZERO and DONE.
REQ-014 In IDLE, on a clock edge with start=1, the block SHALL set R=0, Q=dividend and D=divisor, then go to DZERO if divisor==0 or to CALC with counter=N-1 otherwise.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE and leave all registers unchanged.
REQ-016 Each CALC cycle SHALL:
- shift {R,Q} left one bit;
- compute trial = R_shifted - {0,D};
- if trial is non-negative, set R=trial and Q[0]=1; otherwise keep R_shifted and set Q[0]=0.
REQ-017 CALC SHALL decrement the counter each cycle and go to DONE on the cycle the counter is 0, so exactly N iterations are performed.
REQ-018 DZERO SHALL set Q to all ones, keep the remainder equal to dividend, set div_by_zero=1, and go to DONE in one cycle.
REQ-019 In DONE, the block SHALL:
- load quotient=Q and remainder=R[N-1:0];
- assert done for exactly that cycle;
- set div_by_zero=0 unless arriving from DZERO;
- go to IDLE unconditionally.
REQ-020 Latency SHALL be N+1 cycles from the accepting edge to the done cycle for a non-zero divisor, and 2 cycles for a zero divisor.
REQ-021 The quotient, remainder and div_by_zero outputs SHALL hold their values from the last DONE until the next DONE.
REQ-022 The block SHALL ignore start while busy=1; operands and progress SHALL NOT be disturbed.
REQ-023 If start=1 is held continuously, the block SHALL accept a new operation on the first IDLE edge after DONE, with no back-to-back operation inside DONE.
REQ-024 When dividend < divisor, the block SHALL produce quotient=0 and remainder=dividend.
REQ-025 When divisor==1, the block SHALL produce quotient=dividend and remainder=0.

Reset
REQ-026 Asserting rst_n low SHALL immediately, regardless of clk, force state=IDLE, clear R, Q, D and the counter, and drive quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0.
REQ-027 Reset asserted mid-operation SHALL abandon the division; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL sample start normally.

Structure
REQ-029 A shared package seq_div_pkg SHALL hold the state encoding (IDLE=2'b00, CALC=2'b01, DZERO=2'b10, DONE=2'b11) and the default width constant DIV_WIDTH=4.
REQ-030 The FSM and counter SHALL reside in one sub-module, seq_div_ctrl, which drives load, shift and done strobes to the datapath held in seq_divider.
REQ-031 The implementation SHALL contain no combinational divide or "/" / "%" operators.

Verification
REQ-032 With N=4, start, dividend=13, divisor=3 -> done exactly 5 cycles after the accepting edge, quotient=4, remainder=1, div_by_zero=0.
REQ-033 With N=4, dividend=15, divisor=1 -> quotient=15, remainder=0; then dividend=7, divisor=9 -> quotient=0, remainder=7.
REQ-034 With N=4, dividend=9, divisor=0 -> done 2 cycles after acceptance, quotient=4'hF, remainder=9, div_by_zero=1; a following 8/2 gives quotient=4, remainder=0, div_by_zero=0.
REQ-035 With start=1 and 12/5 accepted, then start pulsed with 6/2 during CALC -> single done with quotient=2, remainder=2, busy=0 after DONE.
REQ-036 With 14/3 accepted, rst_n pulsed low for half a cycle during the 2nd CALC cycle -> outputs 0 immediately, no done pulse, and a subsequent 14/3 yields quotient=4, remainder=2.
REQ-037 An exhaustive sweep of all 256 operand pairs for N=4, compared against a reference model, SHALL show no mismatch and a latency of 5 cycles (or 2 cycles for divisor=0).
